// File: rtl/regbank_write_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | regbank_write_arbiter_pkg : shared constants and helpers            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`include "macros.vh"
`default_nettype none

package regbank_write_arbiter_pkg;

   localparam int          c_DEFAULT_DATA_SIZE = `RWA_DEFAULT_DATA_SIZE;
   localparam int          c_DEFAULT_ADDR_SIZE = `RWA_DEFAULT_ADDR_SIZE;
   localparam int          c_MAX_REQ           = 8;
   localparam logic [15:0] c_CONFLICT_MAX      = 16'hFFFF;

   function automatic int idx_width(input int n);
      return `RWA_CLOG2(n);
   endfunction

   // True when two or more requesters are asking in the same cycle.
   function automatic logic multi_valid(input logic [c_MAX_REQ-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < c_MAX_REQ; i++) begin
         n = n + int'(v[i]);
      end
      return (n >= 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/regbank_write_arbiter_if.sv
// +--------------------------------------------------------------------+
// | regbank_write_arbiter_if : requester bus and bank write port        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface regbank_write_arbiter_if
   import regbank_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = c_DEFAULT_DATA_SIZE,
   parameter int ADDR_SIZE = c_DEFAULT_ADDR_SIZE
) ();

   localparam int c_IDX_W = idx_width(NUM_REQ);

   logic                           stall;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr;
   logic [NUM_REQ*DATA_SIZE-1:0]   req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           wr_enable;
   logic [ADDR_SIZE-1:0]           wr_addr;
   logic [DATA_SIZE-1:0]           wr_data;
   logic [c_IDX_W-1:0]             grant_id;
   logic [15:0]                    conflict_count;

   modport master (
      output stall, req_valid, req_addr, req_data,
      input  req_ready, wr_enable, wr_addr, wr_data, grant_id, conflict_count
   );

   modport slave (
      input  stall, req_valid, req_addr, req_data,
      output req_ready, wr_enable, wr_addr, wr_data, grant_id, conflict_count
   );

endinterface

`default_nettype wire

// File: rtl/macros.vh
// +--------------------------------------------------------------------+
// | macros.vh : shared size defaults and clog2 helper for the arbiter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none
`ifndef RWA_MACROS_VH
`define RWA_MACROS_VH

`define RWA_DEFAULT_DATA_SIZE 32
`define RWA_DEFAULT_ADDR_SIZE 5
// A single requester still needs a 1-bit index.
`define RWA_CLOG2(n) (((n) <= 1) ? 1 : $clog2(n))

`endif
`default_nettype wire

// File: rtl/regbank_write_arbiter_rr_priority_picker.sv
// +--------------------------------------------------------------------+
// | rr_priority_picker : first valid index at or after ptr, wrapping    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  wire logic [NUM_REQ-1:0] valid,
   input  wire logic [IDX_W-1:0]   ptr,
   output logic      [NUM_REQ-1:0] grant,
   output logic      [IDX_W-1:0]   idx,
   output logic                    any_valid
);

   int w_pos;

   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      w_pos     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Explicit wrap keeps non-power-of-two sizes correct.
         w_pos = int'(ptr) + k;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         if (!any_valid && valid[w_pos]) begin
            any_valid    = 1'b1;
            idx          = IDX_W'(w_pos);
            grant[w_pos] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/regbank_write_arbiter.sv
// +--------------------------------------------------------------------+
// | regbank_write_arbiter : round-robin share of the regbank write port |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module regbank_write_arbiter
   import regbank_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = c_DEFAULT_DATA_SIZE,
   parameter int ADDR_SIZE = c_DEFAULT_ADDR_SIZE
) (
   input wire logic               clock,
   input wire logic               reset,
   regbank_write_arbiter_if.slave bus
);

   localparam int                 c_IDX_W = idx_width(NUM_REQ);
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_REQ - 1);

   logic [c_IDX_W-1:0]   r_ptr;
   logic [c_IDX_W-1:0]   r_grant_id;
   logic                 r_wr_enable;
   logic [ADDR_SIZE-1:0] r_wr_addr;
   logic [DATA_SIZE-1:0] r_wr_data;
   logic [15:0]          r_conflict;

   logic [NUM_REQ-1:0]   w_grant;
   logic [c_IDX_W-1:0]   w_idx;
   logic                 w_any;
   logic                 w_xfer;
   logic [ADDR_SIZE-1:0] w_sel_addr;
   logic [DATA_SIZE-1:0] w_sel_data;
   logic [c_MAX_REQ-1:0] w_valid_pad;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_IDX_W)
   ) u_picker (
      .valid     (bus.req_valid),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .idx       (w_idx),
      .any_valid (w_any)
   );

   // Reset also gates the grant so nothing is accepted while it is high.
   assign w_xfer        = w_any & ~bus.stall & ~reset;
   assign bus.req_ready = w_xfer ? w_grant : '0;

   assign w_sel_addr  = bus.req_addr[int'(w_idx)*ADDR_SIZE +: ADDR_SIZE];
   assign w_sel_data  = bus.req_data[int'(w_idx)*DATA_SIZE +: DATA_SIZE];
   assign w_valid_pad = c_MAX_REQ'(bus.req_valid);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr       <= '0;
         r_wr_enable <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_grant_id  <= '0;
         r_conflict  <= '0;
      end else begin
         // x0 writes complete the handshake but never strobe the bank.
         r_wr_enable <= w_xfer && (w_sel_addr != '0);
         if (w_xfer) begin
            r_wr_addr  <= w_sel_addr;
            r_wr_data  <= w_sel_data;
            r_grant_id <= w_idx;
            r_ptr      <= (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
         end
         if (multi_valid(w_valid_pad) && (r_conflict != c_CONFLICT_MAX)) begin
            r_conflict <= r_conflict + 16'd1;
         end
      end
   end

   assign bus.wr_enable      = r_wr_enable;
   assign bus.wr_addr        = r_wr_addr;
   assign bus.wr_data        = r_wr_data;
   assign bus.grant_id       = r_grant_id;
   assign bus.conflict_count = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_regbank_write_arbiter : directed bench with round-robin model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_regbank_write_arbiter;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int DW = 32;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   logic chk_en;
   int   grants[$];

   regbank_write_arbiter_if #(.NUM_REQ(N), .DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

   regbank_write_arbiter #(
      .NUM_REQ   (N),
      .DATA_SIZE (DW),
      .ADDR_SIZE (AW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: first valid requester at or after ptr in circular order.
   function automatic logic [N-1:0] m_pick(input logic [N-1:0] v, input int p, output int w);
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && v[(p + k) % N]) w = (p + k) % N;
      end
      return (w < 0) ? '0 : (N)'(1) << w;
   endfunction

   int          m_ptr;
   logic        m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_gid;
   logic [15:0] m_cc;
   int          mw;
   logic [N-1:0] m_ready;

   always @(negedge clock) begin
      if (chk_en) begin
         m_ready = m_pick(bus.req_valid, m_ptr, mw);
         if (reset || bus.stall) m_ready = '0;
         chk("req_ready", bus.req_ready, m_ready);
         chk("wr_enable", bus.wr_enable, m_en);
         chk("wr_addr", bus.wr_addr, m_addr);
         chk("wr_data", bus.wr_data, m_data);
         chk("grant_id", bus.grant_id, m_gid[1:0]);
         chk("conflict_count", bus.conflict_count, m_cc);
         for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) grants.push_back(i);
         end
         if (reset) begin
            m_ptr = 0; m_en = 0; m_addr = 0; m_data = 0; m_gid = 0; m_cc = 0;
         end else begin
            if (m_ready != '0) begin
               m_addr = bus.req_addr[mw*AW +: AW];
               m_data = bus.req_data[mw*DW +: DW];
               m_en   = (m_addr != 0);
               m_gid  = mw;
               m_ptr  = (mw + 1) % N;
            end else begin
               m_en = 0;
            end
            if ($countones(bus.req_valid) >= 2 && m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      bus.req_addr[i*AW +: AW] = a;
      bus.req_data[i*DW +: DW] = d;
   endtask

   initial begin
      checks = 0; errors = 0; chk_en = 0;
      m_ptr = 0; m_en = 0; m_addr = 0; m_data = 0; m_gid = 0; m_cc = 0;
      reset = 1'b1;
      bus.stall = 1'b0; bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
      tick(); chk_en = 1; tick();
      reset = 1'b0;

      // Idle after reset
      repeat (5) tick();
      chk("idle_ready", bus.req_ready, 0);
      chk("idle_en", bus.wr_enable, 0);
      chk("idle_addr", bus.wr_addr, 0);
      chk("idle_data", bus.wr_data, 0);
      chk("idle_cc", bus.conflict_count, 0);

      // Single requester
      set_req(2, 5'd7, 32'hDEADBEEF);
      bus.req_valid = 4'b0100;
      #1 chk("single_ready", bus.req_ready, 4'b0100);
      tick(); bus.req_valid = '0;
      chk("single_en", bus.wr_enable, 1);
      chk("single_addr", bus.wr_addr, 7);
      chk("single_data", bus.wr_data, 32'hDEADBEEF);
      chk("single_gid", bus.grant_id, 2);
      tick();
      chk("single_drain", bus.wr_enable, 0);

      // Requester 3 brings ptr back to 0
      set_req(3, 5'd3, 32'h3333);
      bus.req_valid = 4'b1000;
      tick(); bus.req_valid = '0;

      // All four continuously for 8 cycles
      for (int i = 0; i < N; i++) set_req(i, 5'(i + 10), 32'hA000 + i);
      grants.delete();
      bus.req_valid = 4'b1111;
      repeat (8) tick();
      bus.req_valid = '0;
      chk("rr_cc", bus.conflict_count, 8);
      chk("rr_count", grants.size(), 8);
      for (int k = 0; k < grants.size() && k < 8; k++) chk("rr_order", grants[k], k % 4);
      chk("rr_last_gid", bus.grant_id, 3);

      // x0 write is accepted but swallowed
      set_req(1, 5'd0, 32'h1);
      bus.req_valid = 4'b0010;
      #1 chk("x0_ready", bus.req_ready, 4'b0010);
      tick(); bus.req_valid = '0;
      chk("x0_en", bus.wr_enable, 0);
      chk("x0_gid", bus.grant_id, 1);
      bus.req_valid = 4'b0110;
      #1 chk("x0_ptr_probe", bus.req_ready, 4'b0100);
      bus.req_valid = '0;

      // Requester 3 brings ptr back to 0
      set_req(3, 5'd4, 32'h44);
      bus.req_valid = 4'b1000;
      tick(); bus.req_valid = '0;

      // Stall holds grants and ptr but keeps counting conflicts
      set_req(0, 5'd8, 32'h80);
      set_req(3, 5'd9, 32'h90);
      bus.stall = 1'b1;
      bus.req_valid = 4'b1001;
      repeat (3) begin
         #1 chk("stall_ready", bus.req_ready, 0);
         tick();
      end
      chk("stall_cc", bus.conflict_count, 11);
      bus.stall = 1'b0;
      #1 chk("unstall_ready0", bus.req_ready, 4'b0001);
      tick(); bus.req_valid = 4'b1000;
      chk("unstall_addr0", bus.wr_addr, 8);
      chk("unstall_gid0", bus.grant_id, 0);
      #1 chk("unstall_ready3", bus.req_ready, 4'b1000);
      tick(); bus.req_valid = '0;
      chk("unstall_addr3", bus.wr_addr, 9);
      chk("unstall_gid3", bus.grant_id, 3);
      chk("unstall_cc", bus.conflict_count, 12);

      // Move ptr to 2, then reset while requests are pending
      set_req(1, 5'd6, 32'h66);
      bus.req_valid = 4'b0010;
      tick();
      set_req(0, 5'd5, 32'h55);
      reset = 1'b1;
      bus.req_valid = 4'b0011;
      #1 chk("rst_ready", bus.req_ready, 0);
      tick();
      reset = 1'b0;
      bus.req_valid = '0;
      chk("rst_en", bus.wr_enable, 0);
      chk("rst_cc", bus.conflict_count, 0);
      chk("rst_addr", bus.wr_addr, 0);
      bus.req_valid = 4'b1010;
      #1 chk("rst_ptr_probe", bus.req_ready, 4'b0010);
      bus.req_valid = '0;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
